cmsdk_iop_gpio_sequencer: RTL and testbench
===========================================

CMSDK_IOP_GPIO_SEQUENCER -- requirements
Module: cmsdk_iop_gpio_sequencer

Interface
REQ-001 SHALL have parameter DEPTH, default 8: number of pattern-table entries (power of 2, 2..16).
REQ-002 SHALL have parameter IWIDTH, default 16: interval counter width.
REQ-003 SHALL have input HCLK, 1 bit: the single clock.
REQ-004 SHALL have input HRESET, 1 bit: synchronous, active-high reset.
REQ-005 SHALL have inputs PAT_WE (1), PAT_IDX ($clog2(DEPTH)) and PAT_DATA (16): pattern-table write port.
REQ-006 SHALL have inputs START (1) and STOP (1): one-cycle command pulses.
REQ-007 SHALL have inputs LEN ($clog2(DEPTH)), INTERVAL (IWIDTH) and REPEAT (8): last entry index, idle cycles between writes, and play count (0 means infinite).
REQ-008 SHALL have host-side inputs H_IOSEL (1), H_IOTRANS (1), H_IOWRITE (1), H_IOSIZE (2), H_IOADDR (12) and H_IOWDATA (32): from the AHB-to-IOP bridge.
REQ-009 SHALL have outputs IOSEL (1), IOTRANS (1), IOWRITE (1), IOSIZE (2), IOADDR (12) and IOWDATA (32): to the GPIO I/O port.
REQ-010 SHALL have outputs BUSY (1), DONE (1, one-cycle pulse) and STALL (1): status.

Function
REQ-011 SHALL implement a sequencer FSM with states IDLE, PEND (write pending) and WAIT (interval countdown).
REQ-012 SHALL, in IDLE on START, sample LEN, INTERVAL and REPEAT, set idx=0 and pass=0, and enter PEND on the next cycle.
REQ-013 SHALL ignore START outside IDLE; STOP has priority over START in the same cycle.
REQ-014 SHALL treat host as active when H_IOSEL & H_IOTRANS; host always wins the I/O port.
REQ-015 SHALL, in PEND with host inactive, issue one write that same cycle: IOSEL=1, IOTRANS=1, IOWRITE=1, IOSIZE=2'b10, IOADDR=12'h004 (DATAOUT), IOWDATA={16'h0, pat[idx]}.
REQ-016 SHALL, in PEND with host active, drive the host signals, stay in PEND and assert STALL for that cycle.
REQ-017 SHALL drive the host signals unchanged, through a combinational mux, in every cycle without a sequencer write.
REQ-018 SHALL, after an issued write with idx≠LEN, increment idx.
REQ-019 SHALL, after an issued write with idx==LEN, increment pass and set idx=0; if REPEAT≠0 and pass+1==REPEAT, it SHALL go to IDLE and pulse DONE on the next cycle.
REQ-020 SHALL, otherwise after an issued write, load the counter with INTERVAL and enter WAIT; with INTERVAL=0 it SHALL enter PEND directly, giving at most one write per cycle.
REQ-021 SHALL, in WAIT, decrement the counter and enter PEND on the cycle after the counter reaches 1; write spacing is INTERVAL+1 cycles when unstalled.
REQ-022 SHALL, on STOP in PEND or WAIT, return to IDLE next cycle with no write in the STOP cycle and no DONE.
REQ-023 SHALL accept PAT_WE in any state; a write to the pending index in the same cycle as issue SHALL send the old value.
REQ-024 SHALL assert BUSY whenever state≠IDLE.
REQ-025 SHALL hold pass as 8 bits; infinite mode (REPEAT=0) wraps pass without effect.

Reset
REQ-026 SHALL, on HRESET at a rising HCLK edge, set state IDLE, idx=0, pass=0, counter=0, BUSY=0, DONE=0 and STALL=0.
REQ-027 SHALL leave the pattern table unreset (contents undefined until written).
REQ-028 SHALL, on reset mid-sequence, suppress any further sequencer write from the next cycle; host passthrough stays active during reset.

Structure
REQ-029 SHALL place the FSM state enum, the DATAOUT offset (12'h004) and the word-size code (2'b10) in shared package cmsdk_gpio_pkg.
REQ-030 SHALL use one sub-module, cmsdk_gpio_pattern_ram: DEPTH x 16 register file with one synchronous write port and an asynchronous read.

Verification
REQ-031 SHALL cover: PAT[0..3]=1,2,4,8, LEN=3, INTERVAL=2, REPEAT=1, START -> writes 0x1,0x2,0x4,0x8 to 0x004 every 3 cycles, then DONE one cycle after the last write, BUSY low.
REQ-032 SHALL cover: INTERVAL=0, LEN=1, REPEAT=3 -> 6 writes on consecutive cycles alternating pat0/pat1, then one DONE.
REQ-033 SHALL cover: host read of 0x000 asserted for 4 cycles during PEND -> host passes through, STALL=1 for those 4 cycles, sequencer write in the 5th cycle with no value lost.
REQ-034 SHALL cover: REPEAT=0, STOP after 10 writes -> no 11th write, IDLE next cycle, DONE never asserted.
REQ-035 SHALL cover: HRESET in WAIT with INTERVAL=100 -> BUSY=0 next cycle, no further writes; a later START restarts at idx 0.
REQ-036 SHALL cover: START and STOP in the same cycle in IDLE -> remains IDLE; START while BUSY -> ignored, sequence unchanged.

Source files
------------

// File: rtl/cmsdk_gpio_pkg.sv
// Shared definitions for the GPIO pattern sequencer: FSM states and I/O port constants.
package cmsdk_gpio_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PEND = 2'd1,
    ST_WAIT = 2'd2
  } seq_state_e;

  localparam logic [11:0] GPIO_DATAOUT_OFS = 12'h004;
  localparam logic [1:0]  IOSIZE_WORD      = 2'b10;

endpackage

// File: rtl/cmsdk_gpio_pattern_ram.sv
// Pattern table: DEPTH x 16 register file, one synchronous write port, asynchronous read.
// Latency: write visible the cycle after PAT_WE; read is combinational.
// Backpressure: none, a write is accepted every cycle.
module cmsdk_gpio_pattern_ram #(
  parameter int DEPTH = 8,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [15:0]   wdata,
  input  logic [AW-1:0] raddr,
  output logic [15:0]   rdata
);

  logic [15:0] mem [DEPTH];

  // No reset: contents are undefined until the host loads them.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/cmsdk_iop_gpio_sequencer.sv
// Plays a pattern table out to the GPIO DATAOUT register, sharing the I/O port with the host.
// Latency: first write the cycle after START, then one write every INTERVAL+1 cycles.
// Backpressure: an active host transfer always wins; the pending write stalls until the port is free.
module cmsdk_iop_gpio_sequencer
  import cmsdk_gpio_pkg::*;
#(
  parameter int DEPTH  = 8,
  parameter int IWIDTH = 16,
  parameter int IDXW   = $clog2(DEPTH)
) (
  input  logic              HCLK,
  input  logic              HRESET,
  input  logic              PAT_WE,
  input  logic [IDXW-1:0]   PAT_IDX,
  input  logic [15:0]       PAT_DATA,
  input  logic              START,
  input  logic              STOP,
  input  logic [IDXW-1:0]   LEN,
  input  logic [IWIDTH-1:0] INTERVAL,
  input  logic [7:0]        REPEAT,
  input  logic              H_IOSEL,
  input  logic              H_IOTRANS,
  input  logic              H_IOWRITE,
  input  logic [1:0]        H_IOSIZE,
  input  logic [11:0]       H_IOADDR,
  input  logic [31:0]       H_IOWDATA,
  output logic              IOSEL,
  output logic              IOTRANS,
  output logic              IOWRITE,
  output logic [1:0]        IOSIZE,
  output logic [11:0]       IOADDR,
  output logic [31:0]       IOWDATA,
  output logic              BUSY,
  output logic              DONE,
  output logic              STALL
);

  seq_state_e        state;
  logic [IDXW-1:0]   idx;
  logic [IDXW-1:0]   len_q;
  logic [IWIDTH-1:0] int_q;
  logic [IWIDTH-1:0] cnt;
  logic [7:0]        rep_q;
  logic [7:0]        pass;
  logic              done_q;
  logic              host_act;
  logic              issue;
  logic              last_entry;
  logic [15:0]       pat_rd;

  cmsdk_gpio_pattern_ram #(.DEPTH(DEPTH), .AW(IDXW)) u_pat (
    .clk   (HCLK),
    .we    (PAT_WE),
    .waddr (PAT_IDX),
    .wdata (PAT_DATA),
    .raddr (idx),
    .rdata (pat_rd)
  );

  assign host_act   = H_IOSEL & H_IOTRANS;
  assign issue      = (state == ST_PEND) & ~host_act & ~STOP;
  assign last_entry = (idx == len_q);

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      state  <= ST_IDLE;
      idx    <= '0;
      pass   <= '0;
      cnt    <= '0;
      len_q  <= '0;
      int_q  <= '0;
      rep_q  <= '0;
      done_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (START && !STOP) begin
            len_q <= LEN;
            int_q <= INTERVAL;
            rep_q <= REPEAT;
            idx   <= '0;
            pass  <= '0;
            state <= ST_PEND;
          end
        end
        ST_PEND: begin
          if (STOP) begin
            state <= ST_IDLE;
          end else if (issue) begin
            if (last_entry) begin
              idx  <= '0;
              pass <= pass + 8'd1;
            end else begin
              idx <= idx + 1'b1;
            end
            // REPEAT of zero never matches, so infinite mode just lets pass wrap.
            if (last_entry && (rep_q != 8'd0) && ((pass + 8'd1) == rep_q)) begin
              state  <= ST_IDLE;
              done_q <= 1'b1;
            end else if (int_q == '0) begin
              state <= ST_PEND;
            end else begin
              cnt   <= int_q;
              state <= ST_WAIT;
            end
          end
        end
        ST_WAIT: begin
          if (STOP) begin
            state <= ST_IDLE;
          end else begin
            cnt <= cnt - IWIDTH'(1);
            if (cnt <= IWIDTH'(1)) state <= ST_PEND;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  always_comb begin
    if (issue) begin
      IOSEL   = 1'b1;
      IOTRANS = 1'b1;
      IOWRITE = 1'b1;
      IOSIZE  = IOSIZE_WORD;
      IOADDR  = GPIO_DATAOUT_OFS;
      IOWDATA = {16'h0000, pat_rd};
    end else begin
      IOSEL   = H_IOSEL;
      IOTRANS = H_IOTRANS;
      IOWRITE = H_IOWRITE;
      IOSIZE  = H_IOSIZE;
      IOADDR  = H_IOADDR;
      IOWDATA = H_IOWDATA;
    end
  end

  assign BUSY  = (state != ST_IDLE);
  assign DONE  = done_q;
  assign STALL = (state == ST_PEND) & host_act;

endmodule

// File: tb/tb_cmsdk_iop_gpio_sequencer.sv
// Bench for the GPIO sequencer: table-driven scenarios, directed corner cases, randomized traffic vs a reference model.
module tb_cmsdk_iop_gpio_sequencer;

  localparam int DEPTH  = 8;
  localparam int IWIDTH = 16;
  localparam int IDXW   = 3;

  logic              HCLK = 1'b0;
  logic              HRESET;
  logic              PAT_WE;
  logic [IDXW-1:0]   PAT_IDX;
  logic [15:0]       PAT_DATA;
  logic              START, STOP;
  logic [IDXW-1:0]   LEN;
  logic [IWIDTH-1:0] INTERVAL;
  logic [7:0]        REPEAT;
  logic              H_IOSEL, H_IOTRANS, H_IOWRITE;
  logic [1:0]        H_IOSIZE;
  logic [11:0]       H_IOADDR;
  logic [31:0]       H_IOWDATA;
  logic              IOSEL, IOTRANS, IOWRITE;
  logic [1:0]        IOSIZE;
  logic [11:0]       IOADDR;
  logic [31:0]       IOWDATA;
  logic              BUSY, DONE, STALL;

  always #5 HCLK = ~HCLK;

  cmsdk_iop_gpio_sequencer #(.DEPTH(DEPTH), .IWIDTH(IWIDTH)) dut (
    .HCLK(HCLK), .HRESET(HRESET),
    .PAT_WE(PAT_WE), .PAT_IDX(PAT_IDX), .PAT_DATA(PAT_DATA),
    .START(START), .STOP(STOP), .LEN(LEN), .INTERVAL(INTERVAL), .REPEAT(REPEAT),
    .H_IOSEL(H_IOSEL), .H_IOTRANS(H_IOTRANS), .H_IOWRITE(H_IOWRITE),
    .H_IOSIZE(H_IOSIZE), .H_IOADDR(H_IOADDR), .H_IOWDATA(H_IOWDATA),
    .IOSEL(IOSEL), .IOTRANS(IOTRANS), .IOWRITE(IOWRITE),
    .IOSIZE(IOSIZE), .IOADDR(IOADDR), .IOWDATA(IOWDATA),
    .BUSY(BUSY), .DONE(DONE), .STALL(STALL)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: a run is "live" with a write due at or after m_elig; nothing about FSM states.
  bit          m_busy = 1'b0;
  int          m_k, m_total, m_len, m_int, m_elig;
  int          step = 0;
  int          done_step = -1;
  logic [15:0] m_pat [DEPTH];

  int          n_wr, n_done, n_stall, last_wr, last_gap;
  logic [15:0] last_data;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (step %0d)", name, act, exp, step);
    end
  endtask

  task automatic tick();
    logic        host, ew, es, ed, old;
    logic [48:0] eio, aio;
    @(negedge HCLK);
    host = H_IOSEL & H_IOTRANS;
    ew   = m_busy && (step >= m_elig) && !host && !STOP;
    es   = m_busy && (step >= m_elig) && host;
    ed   = (step == done_step);
    if (ew) eio = {3'b111, 2'b10, 12'h004, 16'h0000, m_pat[m_k % (m_len + 1)]};
    else    eio = {H_IOSEL, H_IOTRANS, H_IOWRITE, H_IOSIZE, H_IOADDR, H_IOWDATA};
    aio = {IOSEL, IOTRANS, IOWRITE, IOSIZE, IOADDR, IOWDATA};
    chk("io_port", 64'(aio), 64'(eio));
    chk("busy", 64'(BUSY), 64'(m_busy));
    chk("done", 64'(DONE), 64'(ed));
    chk("stall", 64'(STALL), 64'(es));
    if (IOSEL && IOTRANS && IOWRITE && IOADDR == 12'h004 && !host) begin
      n_wr++;
      last_gap  = step - last_wr;
      last_wr   = step;
      last_data = IOWDATA[15:0];
    end
    n_done  += int'(DONE);
    n_stall += int'(STALL);
    if (HRESET) begin
      m_busy = 1'b0;
    end else begin
      old = m_busy;
      if (ew) begin
        m_k++;
        if (m_total != 0 && m_k == m_total) begin
          m_busy    = 1'b0;
          done_step = step + 1;
        end else begin
          m_elig = step + m_int + 1;
        end
      end
      if (old && STOP) m_busy = 1'b0;
      if (!old && START && !STOP) begin
        m_busy  = 1'b1;
        m_k     = 0;
        m_len   = int'(LEN);
        m_int   = int'(INTERVAL);
        m_total = (int'(LEN) + 1) * int'(REPEAT);
        m_elig  = step + 1;
      end
    end
    if (PAT_WE) m_pat[PAT_IDX] = PAT_DATA;
    @(posedge HCLK);
    #1;
    step++;
    START  = 1'b0;
    STOP   = 1'b0;
    PAT_WE = 1'b0;
  endtask

  task automatic load_pat(input int i, input logic [15:0] d);
    PAT_WE = 1'b1; PAT_IDX = IDXW'(i); PAT_DATA = d;
    tick();
  endtask

  task automatic start_seq(input int len, input int intv, input int rep);
    LEN = IDXW'(len); INTERVAL = IWIDTH'(intv); REPEAT = 8'(rep);
    START = 1'b1;
    tick();
  endtask

  task automatic clr_obs();
    n_wr = 0; n_done = 0; n_stall = 0; last_wr = step; last_gap = 0; last_data = 16'h0;
  endtask

  task automatic wait_idle(input int max);
    int n = 0;
    do begin
      tick();
      n++;
    end while (BUSY && n < max);
    chk("idle_timeout", 64'(BUSY), 64'd0);
  endtask

  typedef struct {
    int          len;
    int          intv;
    int          rep;
    int          exp_wr;
    int          exp_gap;
    logic [15:0] exp_last;
  } vec_t;

  vec_t tbl [4];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    tbl[0] = '{len: 3, intv: 2, rep: 1, exp_wr: 4, exp_gap: 3, exp_last: 16'h0008};
    tbl[1] = '{len: 1, intv: 0, rep: 3, exp_wr: 6, exp_gap: 1, exp_last: 16'h0002};
    tbl[2] = '{len: 0, intv: 4, rep: 2, exp_wr: 2, exp_gap: 5, exp_last: 16'h0001};
    tbl[3] = '{len: 7, intv: 1, rep: 1, exp_wr: 8, exp_gap: 2, exp_last: 16'h0080};

    HRESET = 1'b1; PAT_WE = 1'b0; PAT_IDX = '0; PAT_DATA = '0;
    START = 1'b0; STOP = 1'b0; LEN = '0; INTERVAL = '0; REPEAT = '0;
    H_IOSEL = 1'b0; H_IOTRANS = 1'b0; H_IOWRITE = 1'b0; H_IOSIZE = '0; H_IOADDR = '0; H_IOWDATA = '0;
    repeat (2) @(posedge HCLK);
    #1;
    chk("rst_busy", 64'(BUSY), 64'd0);
    chk("rst_done", 64'(DONE), 64'd0);
    chk("rst_stall", 64'(STALL), 64'd0);
    HRESET = 1'b0;
    clr_obs();

    for (int i = 0; i < DEPTH; i++) load_pat(i, 16'(1 << i));

    // Table-driven scenarios, including the 4-write every-3-cycles and back-to-back cases.
    for (int r = 0; r < 4; r++) begin
      clr_obs();
      start_seq(tbl[r].len, tbl[r].intv, tbl[r].rep);
      wait_idle(300);
      tick();
      chk($sformatf("row%0d_writes", r), 64'(n_wr), 64'(tbl[r].exp_wr));
      chk($sformatf("row%0d_gap", r), 64'(last_gap), 64'(tbl[r].exp_gap));
      chk($sformatf("row%0d_last", r), 64'(last_data), 64'(tbl[r].exp_last));
      chk($sformatf("row%0d_dones", r), 64'(n_done), 64'd1);
    end

    // Host holds the port for 4 cycles while a write is pending.
    clr_obs();
    start_seq(3, 2, 1);
    H_IOSEL = 1'b1; H_IOTRANS = 1'b1; H_IOWRITE = 1'b0; H_IOADDR = 12'h000;
    repeat (4) tick();
    H_IOSEL = 1'b0; H_IOTRANS = 1'b0;
    tick();
    chk("host_stalls", 64'(n_stall), 64'd4);
    chk("host_first_wr", 64'(n_wr), 64'd1);
    chk("host_first_data", 64'(last_data), 64'h1);
    wait_idle(100);
    tick();
    chk("host_total_wr", 64'(n_wr), 64'd4);
    chk("host_last_data", 64'(last_data), 64'h8);

    // Infinite mode stopped after 10 writes.
    clr_obs();
    start_seq(2, 1, 0);
    for (int i = 0; i < 100 && n_wr < 10; i++) tick();
    chk("inf_ten_writes", 64'(n_wr), 64'd10);
    STOP = 1'b1;
    tick();
    chk("inf_stop_busy", 64'(BUSY), 64'd0);
    repeat (10) tick();
    chk("inf_no_11th", 64'(n_wr), 64'd10);
    chk("inf_no_done", 64'(n_done), 64'd0);

    // Reset during a long interval, then restart from entry 0.
    clr_obs();
    start_seq(3, 100, 1);
    for (int i = 0; i < 10 && n_wr < 1; i++) tick();
    repeat (5) tick();
    HRESET = 1'b1;
    tick();
    HRESET = 1'b0;
    chk("rst_mid_busy", 64'(BUSY), 64'd0);
    repeat (20) tick();
    chk("rst_mid_writes", 64'(n_wr), 64'd1);
    start_seq(3, 0, 1);
    tick();
    chk("rst_restart_wr", 64'(n_wr), 64'd2);
    chk("rst_restart_idx0", 64'(last_data), 64'h1);
    wait_idle(50);
    tick();

    // START with STOP in IDLE, and START while busy.
    clr_obs();
    START = 1'b1; STOP = 1'b1;
    tick();
    chk("startstop_busy", 64'(BUSY), 64'd0);
    start_seq(3, 2, 1);
    tick();
    tick();
    LEN = '0; INTERVAL = '0; REPEAT = 8'd5; START = 1'b1;
    tick();
    wait_idle(100);
    tick();
    chk("busy_start_wr", 64'(n_wr), 64'd4);
    chk("busy_start_gap", 64'(last_gap), 64'd3);
    chk("busy_start_done", 64'(n_done), 64'd1);

    // Randomized traffic against the reference model.
    for (int run = 0; run < 6; run++) begin
      start_seq($urandom_range(7), $urandom_range(4), $urandom_range(3));
      for (int c = 0; c < 200; c++) begin
        H_IOSEL   = ($urandom_range(2) == 0);
        H_IOTRANS = ($urandom_range(1) == 0);
        H_IOWRITE = 1'($urandom);
        H_IOSIZE  = 2'($urandom);
        H_IOADDR  = 12'($urandom);
        H_IOWDATA = $urandom;
        PAT_WE    = ($urandom_range(9) == 0);
        PAT_IDX   = IDXW'($urandom);
        PAT_DATA  = 16'($urandom);
        STOP      = ($urandom_range(60) == 0);
        START     = ($urandom_range(20) == 0);
        LEN       = IDXW'($urandom);
        INTERVAL  = IWIDTH'($urandom_range(3));
        REPEAT    = 8'($urandom_range(3));
        tick();
      end
      H_IOSEL = 1'b0; H_IOTRANS = 1'b0;
      STOP = 1'b1;
      tick();
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
